// File: rtl/text_display_writer.sv
// Character stream to text-mode RAM writer: prints bytes at the cursor, handles CR/LF,
// and sweeps the whole screen with BLANK when the cursor counter signals a wrap.
module text_display_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  cursor_x,
  input  logic [4:0]  cursor_y,
  input  logic        clear_screen,
  output logic        inc_cursor,
  output logic        carriage_cursor,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic [2:0]  dbg_state_o
);

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is high only in IDLE and the sender must hold data until then.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    ADVANCE = 3'd2,
    NEWLINE = 3'd3,
    CLEAR   = 3'd4
  } state_t;

  localparam logic [11:0] COLS_W    = 12'(COLS);
  localparam logic [11:0] LAST_ADDR = 12'(COLS * ROWS - 1);

  state_t      state_q;
  logic [7:0]  char_q;
  logic [11:0] clr_cnt_q;

  logic        is_printable;
  logic        is_newline;
  logic [11:0] cursor_addr;

  assign is_printable = (in_data >= 8'h20) && (in_data <= 8'h7E);
  assign is_newline   = (in_data == 8'h0D) || (in_data == 8'h0A);
  assign cursor_addr  = 12'(cursor_y) * COLS_W + 12'(cursor_x);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      char_q    <= 8'h00;
      clr_cnt_q <= 12'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            char_q <= in_data;
            if (is_printable)    state_q <= WRITE;
            else if (is_newline) state_q <= NEWLINE;
          end
        end
        WRITE:   state_q <= ADVANCE;
        ADVANCE: state_q <= clear_screen ? CLEAR : IDLE;
        NEWLINE: state_q <= clear_screen ? CLEAR : IDLE;
        CLEAR: begin
          if (clr_cnt_q == LAST_ADDR) begin
            clr_cnt_q <= 12'd0;
            state_q   <= IDLE;
          end else begin
            clr_cnt_q <= clr_cnt_q + 12'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; WRITE takes the cursor position live.
  always_comb begin
    in_ready        = 1'b0;
    inc_cursor      = 1'b0;
    carriage_cursor = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = 12'd0;
    mem_data        = 8'h00;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      WRITE: begin
        mem_we   = 1'b1;
        mem_addr = cursor_addr;
        mem_data = char_q;
      end
      ADVANCE: inc_cursor = 1'b1;
      NEWLINE: carriage_cursor = 1'b1;
      CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt_q;
        mem_data = BLANK;
      end
      default: ;
    endcase
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_text_display_writer.sv
// Directed bench for text_display_writer with a small cursor-counter model
// and a write scoreboard for the back-to-back streaming case.
module tb_text_display_writer;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        clear_screen;
  logic        inc_cursor;
  logic        carriage_cursor;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;

  logic       load_en = 1'b0;
  logic [6:0] load_x  = '0;
  logic [4:0] load_y  = '0;

  text_display_writer dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cursor_x       (cursor_x),
    .cursor_y       (cursor_y),
    .clear_screen   (clear_screen),
    .inc_cursor     (inc_cursor),
    .carriage_cursor(carriage_cursor),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .dbg_state_o    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cursor counter model: wraps at the screen end and flags clear_screen.
  assign clear_screen = (inc_cursor && cursor_x == 7'd79 && cursor_y == 5'd29) ||
                        (carriage_cursor && cursor_y == 5'd29);

  always @(posedge clk) begin
    if (load_en) begin
      cursor_x <= load_x;
      cursor_y <= load_y;
    end else if (inc_cursor) begin
      if (cursor_x == 7'd79) begin
        cursor_x <= 7'd0;
        cursor_y <= (cursor_y == 5'd29) ? 5'd0 : cursor_y + 5'd1;
      end else begin
        cursor_x <= cursor_x + 7'd1;
      end
    end else if (carriage_cursor) begin
      cursor_x <= 7'd0;
      cursor_y <= (cursor_y == 5'd29) ? 5'd0 : cursor_y + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks: called at a negedge while in_ready is high; return one negedge later.
  task automatic drive_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_cursor(input logic [6:0] x, input logic [4:0] y);
    load_en = 1'b1;
    load_x  = x;
    load_y  = y;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Scoreboard: every RAM write while enabled must match the next expected byte.
  always @(negedge clk) begin
    if (mon_en && mem_we) begin
      if (exp_q.size() > 0) check("sb_write_data", {24'd0, mem_data}, {24'd0, exp_q.pop_front()});
      else                  check("sb_unexpected_write", {24'd0, mem_data}, 32'hFF);
    end
  end

  initial begin
    int errs;
    logic [7:0] stream [7];
    stream = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67};
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    load_en  = 1'b1;
    repeat (2) @(negedge clk);
    load_en = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, in_ready}, 1);
    check("rst_mem_we", {31'd0, mem_we}, 0);
    check("rst_mem_addr", {20'd0, mem_addr}, 0);
    check("rst_mem_data", {24'd0, mem_data}, 0);
    check("rst_inc", {31'd0, inc_cursor}, 0);
    check("rst_carriage", {31'd0, carriage_cursor}, 0);
    check("rst_state", {29'd0, dbg_state}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Printable byte at (3,2)
    load_cursor(7'd3, 5'd2);
    check("a_ready_before", {31'd0, in_ready}, 1);
    drive_byte(8'h41);
    check("a_we", {31'd0, mem_we}, 1);
    check("a_addr", {20'd0, mem_addr}, 163);
    check("a_data", {24'd0, mem_data}, 32'h41);
    check("a_inc_early", {31'd0, inc_cursor}, 0);
    check("a_ready_busy", {31'd0, in_ready}, 0);
    @(negedge clk);
    check("a_inc", {31'd0, inc_cursor}, 1);
    check("a_we_adv", {31'd0, mem_we}, 0);
    check("a_addr_adv", {20'd0, mem_addr}, 0);
    check("a_carriage_adv", {31'd0, carriage_cursor}, 0);
    @(negedge clk);
    check("a_ready_after", {31'd0, in_ready}, 1);
    check("a_inc_after", {31'd0, inc_cursor}, 0);

    // CR then LF
    drive_byte(8'h0D);
    check("cr_carriage", {31'd0, carriage_cursor}, 1);
    check("cr_we", {31'd0, mem_we}, 0);
    check("cr_inc", {31'd0, inc_cursor}, 0);
    check("cr_ready", {31'd0, in_ready}, 0);
    @(negedge clk);
    check("cr_ready_after", {31'd0, in_ready}, 1);
    drive_byte(8'h0A);
    check("lf_carriage", {31'd0, carriage_cursor}, 1);
    check("lf_we", {31'd0, mem_we}, 0);
    @(negedge clk);
    check("lf_ready_after", {31'd0, in_ready}, 1);
    check("lf_carriage_after", {31'd0, carriage_cursor}, 0);

    // Non-printable bytes are discarded
    drive_byte(8'h07);
    check("bel_ready", {31'd0, in_ready}, 1);
    check("bel_we", {31'd0, mem_we}, 0);
    check("bel_pulses", {30'd0, inc_cursor, carriage_cursor}, 0);
    drive_byte(8'h7F);
    check("del_ready", {31'd0, in_ready}, 1);
    check("del_we", {31'd0, mem_we}, 0);
    check("del_pulses", {30'd0, inc_cursor, carriage_cursor}, 0);

    // Last cell write triggers a full clear sweep
    load_cursor(7'd79, 5'd29);
    drive_byte(8'h5A);
    check("z_addr", {20'd0, mem_addr}, 2399);
    check("z_data", {24'd0, mem_data}, 32'h5A);
    @(negedge clk);
    check("z_inc", {31'd0, inc_cursor}, 1);
    errs = 0;
    for (int k = 0; k < 2400; k++) begin
      @(negedge clk);
      if (k == 0) check("clr_first_addr", {20'd0, mem_addr}, 0);
      if (!(mem_we === 1'b1 && mem_addr === 12'(k) && mem_data === 8'h20 && in_ready === 1'b0))
        errs++;
    end
    check("clr_sweep_errs", errs, 0);
    @(negedge clk);
    check("clr_done_ready", {31'd0, in_ready}, 1);
    check("clr_done_we", {31'd0, mem_we}, 0);

    // Newline on the last row, then reset in the middle of the sweep
    load_cursor(7'd10, 5'd29);
    drive_byte(8'h0D);
    check("nl_carriage", {31'd0, carriage_cursor}, 1);
    repeat (1001) @(negedge clk);
    check("mid_clr_addr", {20'd0, mem_addr}, 1000);
    check("mid_clr_we", {31'd0, mem_we}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_clr_we", {31'd0, mem_we}, 0);
    check("rst_clr_ready", {31'd0, in_ready}, 1);
    check("rst_clr_addr", {20'd0, mem_addr}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("no_resume_we", {31'd0, mem_we}, 0);
    load_cursor(7'd5, 5'd1);
    drive_byte(8'h42);
    check("post_rst_addr", {20'd0, mem_addr}, 85);
    check("post_rst_data", {24'd0, mem_data}, 32'h42);
    repeat (2) @(negedge clk);

    // Streaming with in_valid held high: only IDLE-edge bytes are written
    load_cursor(7'd0, 5'd0);
    exp_q.push_back(8'h61);
    exp_q.push_back(8'h64);
    exp_q.push_back(8'h67);
    mon_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_data  = stream[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    check("sb_remaining", exp_q.size(), 0);
    check("stream_ready_end", {31'd0, in_ready}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
